csr_file: RTL
=============

Name: csr_file

Overview:
- Machine-mode CSR responder in the EX stage.
- Consumes the registered CSR fields from the ID/EX stage register: func3, zimm, csr_addr, csr_write_en, is_csr.
- Returns the old CSR value for rd and performs the read-modify-write at the clock edge.
- Owns the free-running cycle counter and the retired-instruction counter.

Parameters:
- XLEN, 32, data width of CSRs and rs1 operand
- MTVEC_RESET, 32'h0000_0000, reset value of mtvec (bits [1:0] forced 0)

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- bubbleE  in  1  EX stalled; no CSR write, no minstret increment this cycle
- flushE  in  1  EX instruction squashed; no CSR write
- is_csr  in  1  EX instruction is a CSR op
- csr_write_en  in  1  CSR op writes (decoder clears it for CSRRS/CSRRC with rs1/zimm = 0)
- func3  in  3  CSR op select
- zimm  in  5  immediate operand for CSRR*I
- csr_addr  in  12  CSR address
- rs1_data  in  XLEN  forwarded rs1 operand
- retire  in  1  one instruction retired this cycle (WB valid)
- csr_rdata  out  XLEN  old CSR value, goes to rd
- csr_illegal  out  1  unmapped address accessed by a CSR op

Behaviour:
- Reset is asynchronous and active-high (rst).
  - All CSRs reset to 0, except mtvec = {MTVEC_RESET[XLEN-1:2], 2'b00}.
- Implemented CSRs:
  - mstatus 0x300: only bits 3 (MIE) and 7 (MPIE) are writable; other bits read 0.
  - mie 0x304: full width.
  - mtvec 0x305: bits [1:0] read 0.
  - mscratch 0x340: full width.
  - mepc 0x341: bits [1:0] read 0.
  - mcause 0x342: full width.
  - mcycle 0xB00.
  - minstret 0xB02.
- Read path is combinational.
  - csr_rdata = current value at csr_addr when is_csr = 1 and the address is mapped; else 0.
- csr_illegal = is_csr & unmapped address (combinational).
- Operand: src = func3[2] ? {XLEN-5 zeros, zimm} : rs1_data.
- New value by func3[1:0]:
  - 01 (RW/RWI): src
  - 10 (RS/RSI): old | src
  - 11 (RC/RCI): old & ~src
  - 00: no write
- Write fires at posedge clk iff is_csr & csr_write_en & ~bubbleE & ~flushE & ~csr_illegal & func3[1:0] != 00. Field masks are applied on write.
- Latency: the write is visible to the next instruction's combinational read one cycle later. No internal forwarding is needed.
- mcycle: +1 every cycle, wraps to 0 at all-ones.
- minstret: +1 on cycles where retire = 1, independent of bubbleE. Wraps to 0.
- Simultaneous software write and increment on the same counter: the software write wins; that cycle's increment is dropped.
- Reset mid-operation: all state returns to reset values immediately. A pending write is lost.
- bubbleE held: the same CSR op may sit in EX for multiple cycles. It writes exactly once, on the first cycle with bubbleE = 0 (upstream holds the inputs stable).

Optional Feature:
- Macro: CSR_COUNTER_64_EN
- Defined:
  - mcycle and minstret are 64-bit.
  - Low halves at 0xB00/0xB02; high halves mcycleh 0xB80 and minstreth 0xB82 are readable and writable.
  - Carry propagates from the low to the high half.
  - A write to either half replaces only that half, and suppresses the increment for that cycle.
- Undefined:
  - Counters are XLEN-bit.
  - 0xB80/0xB82 are unmapped and raise csr_illegal.

Test Plan:
- Reset then read:
  - is_csr=1, csr_addr=0x305, MTVEC_RESET=0x1003 -> csr_rdata=0x1000.
  - csr_addr=0x342 -> csr_rdata=0.
- CSRRW mscratch:
  - func3=001, rs1_data=0xDEADBEEF, csr_write_en=1 -> csr_rdata=0.
  - Next cycle, read of 0x340 -> 0xDEADBEEF.
- Set/clear sequence on mscratch=0xF0:
  - CSRRSI zimm=0x0F -> rdata=0xF0, then value=0xFF.
  - CSRRC rs1_data=0x3C -> rdata=0xFF, then value=0xC3.
- mstatus mask: CSRRW 0xFFFFFFFF -> read-back 0x00000088.
- Squash and stall:
  - flushE=1 with CSRRW mie=0x5 -> mie stays 0.
  - bubbleE=1 for 3 cycles then 0, with CSRRS mie rs1=0x1 -> single write, mie=0x1.
- Counters:
  - retire pulsed 4 times over 10 cycles after reset -> minstret=4, mcycle=10.
  - Write mcycle=0xFFFFFFFF -> following cycle reads 0xFFFFFFFF; next cycle reads 0 (wrap; with CSR_COUNTER_64_EN, mcycleh=1).
  - Unmapped 0x7C0 -> csr_illegal=1, csr_rdata=0, no state change.

Source files
------------

// File: rtl/csr_file.sv
`default_nettype none
// ============================================================================
//  Module      : csr_file
//  Description : Machine-mode CSR responder for the EX stage. Combinational
//                read of the old CSR value, read-modify-write at the clock
//                edge, and ownership of the mcycle / minstret counters.
//                Optional feature macro: CSR_COUNTER_64_EN (64-bit counters
//                with mcycleh / minstreth high halves).
//  Revision    : 1.0 - initial release
// ============================================================================
module csr_file #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            bubbleE,
    input  logic            flushE,
    input  logic            is_csr,
    input  logic            csr_write_en,
    input  logic [2:0]      func3,
    input  logic [4:0]      zimm,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic            retire,
    output logic [XLEN-1:0] csr_rdata,
    output logic            csr_illegal
);

`ifdef CSR_COUNTER_64_EN
    localparam int CNT_W = 2 * XLEN;
`else
    localparam int CNT_W = XLEN;
`endif

    localparam logic [11:0] c_ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] c_ADDR_MIE      = 12'h304;
    localparam logic [11:0] c_ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] c_ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] c_ADDR_MEPC     = 12'h341;
    localparam logic [11:0] c_ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] c_ADDR_MCYCLE   = 12'hB00;
    localparam logic [11:0] c_ADDR_MINSTRET = 12'hB02;
`ifdef CSR_COUNTER_64_EN
    localparam logic [11:0] c_ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] c_ADDR_MINSTRETH = 12'hB82;
`endif

    localparam logic [1:0] c_OP_RW = 2'b01;
    localparam logic [1:0] c_OP_RS = 2'b10;
    localparam logic [1:0] c_OP_RC = 2'b11;

    // ------------------------------------------------------------------------
    // Architectural state (only implemented bits are stored)
    // ------------------------------------------------------------------------
    logic             r_mstatus_mie;
    logic             r_mstatus_mpie;
    logic [XLEN-1:0]  r_mie;
    logic [XLEN-1:2]  r_mtvec;
    logic [XLEN-1:0]  r_mscratch;
    logic [XLEN-1:2]  r_mepc;
    logic [XLEN-1:0]  r_mcause;
    logic [CNT_W-1:0] r_mcycle;
    logic [CNT_W-1:0] r_minstret;

    logic [XLEN-1:0]  w_mstatus;
    logic [XLEN-1:0]  w_old;
    logic             w_hit;
    logic [XLEN-1:0]  w_src;
    logic [XLEN-1:0]  w_new;
    logic             w_wr;
    logic             w_wr_mstatus;
    logic             w_wr_mie;
    logic             w_wr_mtvec;
    logic             w_wr_mscratch;
    logic             w_wr_mepc;
    logic             w_wr_mcause;
    logic             w_wr_mcycle;
    logic             w_wr_minstret;
`ifdef CSR_COUNTER_64_EN
    logic             w_wr_mcycleh;
    logic             w_wr_minstreth;
`endif

    // Assemble the architectural mstatus view from its two stored bits
    always_comb begin
        w_mstatus    = '0;
        w_mstatus[3] = r_mstatus_mie;
        w_mstatus[7] = r_mstatus_mpie;
    end

    // Address decode and old-value mux; w_hit is low for unmapped addresses
    always_comb begin
        w_hit = 1'b1;
        w_old = '0;
        case (csr_addr)
            c_ADDR_MSTATUS:   w_old = w_mstatus;
            c_ADDR_MIE:       w_old = r_mie;
            c_ADDR_MTVEC:     w_old = {r_mtvec, 2'b00};
            c_ADDR_MSCRATCH:  w_old = r_mscratch;
            c_ADDR_MEPC:      w_old = {r_mepc, 2'b00};
            c_ADDR_MCAUSE:    w_old = r_mcause;
            c_ADDR_MCYCLE:    w_old = r_mcycle[XLEN-1:0];
            c_ADDR_MINSTRET:  w_old = r_minstret[XLEN-1:0];
`ifdef CSR_COUNTER_64_EN
            c_ADDR_MCYCLEH:   w_old = r_mcycle[CNT_W-1:XLEN];
            c_ADDR_MINSTRETH: w_old = r_minstret[CNT_W-1:XLEN];
`endif
            default:          w_hit = 1'b0;
        endcase
    end

    assign csr_rdata   = (is_csr && w_hit) ? w_old : '0;
    assign csr_illegal = is_csr & ~w_hit;

    // Operand select: zero-extended immediate for the CSRR*I forms
    assign w_src = func3[2] ? {{(XLEN-5){1'b0}}, zimm} : rs1_data;

    // Read-modify-write value before field masking
    always_comb begin
        w_new = w_old;
        case (func3[1:0])
            c_OP_RW: w_new = w_src;
            c_OP_RS: w_new = w_old | w_src;
            c_OP_RC: w_new = w_old & ~w_src;
            default: w_new = w_old;
        endcase
    end

    // A stalled or squashed op never writes; a held op therefore writes
    // exactly once, on the cycle it leaves EX.
    assign w_wr = is_csr & csr_write_en & ~bubbleE & ~flushE & w_hit
                & (func3[1:0] != 2'b00);

    assign w_wr_mstatus   = w_wr & (csr_addr == c_ADDR_MSTATUS);
    assign w_wr_mie       = w_wr & (csr_addr == c_ADDR_MIE);
    assign w_wr_mtvec     = w_wr & (csr_addr == c_ADDR_MTVEC);
    assign w_wr_mscratch  = w_wr & (csr_addr == c_ADDR_MSCRATCH);
    assign w_wr_mepc      = w_wr & (csr_addr == c_ADDR_MEPC);
    assign w_wr_mcause    = w_wr & (csr_addr == c_ADDR_MCAUSE);
    assign w_wr_mcycle    = w_wr & (csr_addr == c_ADDR_MCYCLE);
    assign w_wr_minstret  = w_wr & (csr_addr == c_ADDR_MINSTRET);
`ifdef CSR_COUNTER_64_EN
    assign w_wr_mcycleh   = w_wr & (csr_addr == c_ADDR_MCYCLEH);
    assign w_wr_minstreth = w_wr & (csr_addr == c_ADDR_MINSTRETH);
`endif

    // Trap-related machine CSRs with their field masks applied on write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mstatus_mie  <= 1'b0;
            r_mstatus_mpie <= 1'b0;
            r_mie          <= '0;
            r_mtvec        <= MTVEC_RESET[XLEN-1:2];
            r_mscratch     <= '0;
            r_mepc         <= '0;
            r_mcause       <= '0;
        end else begin
            if (w_wr_mstatus) begin
                r_mstatus_mie  <= w_new[3];
                r_mstatus_mpie <= w_new[7];
            end
            if (w_wr_mie) begin
                r_mie <= w_new;
            end
            if (w_wr_mtvec) begin
                r_mtvec <= w_new[XLEN-1:2];
            end
            if (w_wr_mscratch) begin
                r_mscratch <= w_new;
            end
            if (w_wr_mepc) begin
                r_mepc <= w_new[XLEN-1:2];
            end
            if (w_wr_mcause) begin
                r_mcause <= w_new;
            end
        end
    end

    // Free-running cycle counter; a software write to either half wins
    // over that cycle's increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mcycle <= '0;
        end else if (w_wr_mcycle) begin
            r_mcycle[XLEN-1:0] <= w_new;
`ifdef CSR_COUNTER_64_EN
        end else if (w_wr_mcycleh) begin
            r_mcycle[CNT_W-1:XLEN] <= w_new;
`endif
        end else begin
            r_mcycle <= r_mcycle + CNT_W'(1);
        end
    end

    // Retired-instruction counter; counts WB retirements regardless of stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_minstret <= '0;
        end else if (w_wr_minstret) begin
            r_minstret[XLEN-1:0] <= w_new;
`ifdef CSR_COUNTER_64_EN
        end else if (w_wr_minstreth) begin
            r_minstret[CNT_W-1:XLEN] <= w_new;
`endif
        end else if (retire) begin
            r_minstret <= r_minstret + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire
